// File: rtl/dmem_bytelane_pkg.sv
// Shared encodings for the byte-lane data memory: access sizes, FSM states, access direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_bytelane_pkg;

   // Access size as carried on req_size.
   typedef enum logic [1:0] {
      SIZE_B   = 2'b00,
      SIZE_H   = 2'b01,
      SIZE_W   = 2'b10,
      SIZE_RSV = 2'b11
   } size_t;

   // Response FSM: IDLE holds nothing, RESP holds a response until it is taken.
   typedef enum logic {
      DMEM_IDLE = 1'b0,
      DMEM_RESP = 1'b1
   } dmem_state_t;

   // Direction encoding of req_we, kept from the word-only memory.
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b0;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering: store byte-enables/replication and load shift + sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies all outputs with its own accept.
module dmem_lane_align
   import dmem_bytelane_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            i_size,
   input  logic                  i_unsigned,
   input  logic [1:0]            i_lane,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [DATA_WIDTH-1:0] i_rword,
   output logic [DATA_WIDTH/8-1:0] o_be,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic [DATA_WIDTH-1:0] o_ldata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [NB-1:0]         w_one;
   logic [NB-1:0]         w_two;
   logic [DATA_WIDTH-1:0] w_shift;
   logic                  w_sext_b;
   logic                  w_sext_h;

   assign w_one    = {{(NB-1){1'b0}}, 1'b1};
   assign w_two    = {{(NB-2){1'b0}}, 2'b11};
   assign w_shift  = i_rword >> {i_lane, 3'b000};
   assign w_sext_b = ~i_unsigned & w_shift[7];
   assign w_sext_h = ~i_unsigned & w_shift[15];

   // Store side: one-hot/pair/all lane enables; narrow data copied into every lane it could land in.
   always_comb begin
      o_be    = '0;
      o_wdata = i_wdata;
      case (size_t'(i_size))
         SIZE_B: begin
            o_be    = w_one << i_lane;
            o_wdata = {NB{i_wdata[7:0]}};
         end
         SIZE_H: begin
            o_be    = w_two << i_lane;
            o_wdata = {(NB/2){i_wdata[15:0]}};
         end
         SIZE_W: begin
            o_be    = '1;
         end
         default: begin
            o_be    = '0;
         end
      endcase
   end

   // Load side: word already shifted down by lane; mask to size and extend.
   always_comb begin
      o_ldata = w_shift;
      case (size_t'(i_size))
         SIZE_B:  o_ldata = {{(DATA_WIDTH-8){w_sext_b}}, w_shift[7:0]};
         SIZE_H:  o_ldata = {{(DATA_WIDTH-16){w_sext_h}}, w_shift[15:0]};
         default: o_ldata = w_shift;
      endcase
   end

endmodule

// File: rtl/dmem_bytelane.sv
// Data memory with RV32 byte/half/word sizing, range/size checks; DMEM_MISALIGN_CHK_EN flags misalignment.
// Latency: response (load data or store ack) registered, visible the cycle after accept.
// Backpressure: a held response blocks new requests unless resp_ready takes it the same cycle.
module dmem_bytelane
   import dmem_bytelane_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = DATA_WIDTH / 8;

   dmem_state_t           r_state;
   dmem_state_t           w_state_nxt;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_accept;
   logic                  w_is_store;
   logic                  w_is_load;
   logic                  w_oor;
   logic                  w_size_err;
   logic                  w_mis;
   logic                  w_err;
   logic                  w_wr;
   logic [1:0]            w_lane;
   logic [IDX_W-1:0]      w_idx;
   logic [DATA_WIDTH-1:0] w_rword;
   logic [NB-1:0]         w_be;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_ldata;

   assign req_ready  = (r_state == DMEM_IDLE) | ((r_state == DMEM_RESP) & resp_ready);
   // No request is taken while reset is asserted, so no write can slip through.
   assign w_accept   = req_valid & req_ready & RSTn;
   assign w_is_store = (req_we == WriteEnable);
   assign w_is_load  = (req_we == ReadEnable);

   assign w_oor      = |(req_addr >> (IDX_W + 2));
   assign w_size_err = (size_t'(req_size) == SIZE_RSV);
   assign w_idx      = req_addr[IDX_W+1:2];

`ifdef DMEM_MISALIGN_CHK_EN
   // Misaligned halves/words are rejected; lane taken straight from the address.
   assign w_mis  = ((size_t'(req_size) == SIZE_H) & req_addr[0]) |
                   ((size_t'(req_size) == SIZE_W) & (|req_addr[1:0]));
   assign w_lane = req_addr[1:0];
`else
   assign w_mis  = 1'b0;
   // Misaligned low bits are dropped to the natural alignment of the access.
   always_comb begin
      w_lane = req_addr[1:0];
      case (size_t'(req_size))
         SIZE_H:  w_lane = {req_addr[1], 1'b0};
         SIZE_W:  w_lane = 2'b00;
         default: w_lane = req_addr[1:0];
      endcase
   end
`endif

   assign w_err   = w_oor | w_size_err | w_mis;
   assign w_wr    = w_accept & w_is_store & ~w_err;
   assign w_rword = r_mem[w_idx];

   dmem_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .i_size     (req_size),
      .i_unsigned (req_unsigned),
      .i_lane     (w_lane),
      .i_wdata    (req_wdata),
      .i_rword    (w_rword),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_ldata    (w_ldata)
   );

   // Array write: only enabled lanes of an accepted, error-free store; contents are never reset.
   always_ff @(posedge CLK) begin
      for (int b = 0; b < NB; b++) begin
         if (w_wr && w_be[b]) begin
            r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= DMEM_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: accept always loads a response; a taken response without a new accept returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DMEM_IDLE: if (w_accept) w_state_nxt = DMEM_RESP;
         DMEM_RESP: if (resp_ready && !w_accept) w_state_nxt = DMEM_IDLE;
         default:   w_state_nxt = DMEM_IDLE;
      endcase
   end

   // Response registers: loaded on accept, otherwise held so a stalled consumer sees stable outputs.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_rdata <= (w_err || !w_is_load) ? '0 : w_ldata;
         r_err   <= w_err;
      end
   end

   assign resp_valid = (r_state == DMEM_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane: sizing, extension, errors, backpressure, reset mid-response.
// Latency: expects each response one cycle after its accept edge.
// Backpressure: drives resp_ready low to stall and checks req_ready/output stability.
module tb_dmem_bytelane;

   logic        CLK;
   logic        RSTn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int checks;
   int failures;

   dmem_bytelane #(
      .DATA_WIDTH (32),
      .DEPTH      (1024),
      .ADDR_WIDTH (32)
   ) dut (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Present one request, wait (bounded) for acceptance, return 1 time unit after the accept edge.
   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      checks++;
      if (!req_ready) begin
         failures++;
         $display("FAIL issue_timeout addr=%h ready=%b required=1", addr, req_ready);
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      RSTn = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
      checks++;
      if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", resp_rdata); end
      checks++;
      if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", resp_err); end
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      RSTn = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic test_word;
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
         failures++; $display("FAIL sw_ack v=%b e=%b d=%h exp v=1 e=0 d=00000000", resp_valid, resp_err, resp_rdata);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checks++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL lw_10 v=%b e=%b d=%h exp v=1 e=0 d=deadbeef", resp_valid, resp_err, resp_rdata);
      end
   endtask

   task automatic test_byte;
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
      issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h80);
      issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      checks++;
      if (resp_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_11 got=%h exp=ffffff80", resp_rdata); end
      issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      checks++;
      if (resp_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_11 got=%h exp=00000080", resp_rdata); end
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checks++;
      if (resp_rdata !== 32'h00008000) begin failures++; $display("FAIL lw_after_sb got=%h exp=00008000", resp_rdata); end
   endtask

   task automatic test_half;
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
      issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234);
      issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
      checks++;
      if (resp_rdata !== 32'h00001234) begin failures++; $display("FAIL lh_22 got=%h exp=00001234", resp_rdata); end
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checks++;
      if (resp_rdata !== 32'h12340000) begin failures++; $display("FAIL lw_after_sh got=%h exp=12340000", resp_rdata); end
      issue(1'b1, 2'b01, 1'b0, 32'h20, 32'h8001);
      issue(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
      checks++;
      if (resp_rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_20_sext got=%h exp=ffff8001", resp_rdata); end
      issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
      checks++;
      if (resp_rdata !== 32'h00008001) begin failures++; $display("FAIL lhu_20 got=%h exp=00008001", resp_rdata); end
      issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checks++;
      if (resp_rdata !== 32'h12348001) begin failures++; $display("FAIL lw_20_both got=%h exp=12348001", resp_rdata); end
   endtask

   task automatic test_errors;
      issue(1'b1, 2'b10, 1'b0, 32'h0, 32'h11111111);
      issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
      checks++;
      if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         failures++; $display("FAIL lw_oor e=%b d=%h exp e=1 d=00000000", resp_err, resp_rdata);
      end
      // Out-of-range store aliases word 0 by index; it must not land there.
      issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF);
      checks++;
      if (resp_err !== 1'b1) begin failures++; $display("FAIL sw_oor_err got=%b exp=1", resp_err); end
      issue(1'b1, 2'b11, 1'b0, 32'h0, 32'h22222222);
      checks++;
      if (resp_err !== 1'b1) begin failures++; $display("FAIL sw_rsv_err got=%b exp=1", resp_err); end
      issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 32'h11111111) begin
         failures++; $display("FAIL lw_0_no_err_write e=%b d=%h exp e=0 d=11111111", resp_err, resp_rdata);
      end
      issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      checks++;
      if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         failures++; $display("FAIL ld_rsv e=%b d=%h exp e=1 d=00000000", resp_err, resp_rdata);
      end
      issue(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D);
      issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 32'hCAFEF00D) begin
         failures++; $display("FAIL lw_last e=%b d=%h exp e=0 d=cafef00d", resp_err, resp_rdata);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifdef DMEM_MISALIGN_CHK_EN
      checks++;
      if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         failures++; $display("FAIL lw_13_mis e=%b d=%h exp e=1 d=00000000", resp_err, resp_rdata);
      end
      issue(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
      checks++;
      if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
         failures++; $display("FAIL lh_23_mis e=%b d=%h exp e=1 d=00000000", resp_err, resp_rdata);
      end
`else
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 32'h00008000) begin
         failures++; $display("FAIL lw_13_align e=%b d=%h exp e=0 d=00008000", resp_err, resp_rdata);
      end
      issue(1'b0, 2'b01, 1'b0, 32'h23, 32'h0);
      checks++;
      if (resp_err !== 1'b0 || resp_rdata !== 32'h00001234) begin
         failures++; $display("FAIL lh_23_align e=%b d=%h exp e=0 d=00001234", resp_err, resp_rdata);
      end
`endif
   endtask

   task automatic test_back_to_back;
      @(posedge CLK); #1;
      resp_ready = 1'b0;
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      // Competing request while stalled must not be taken.
      req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = '0; req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'h00008000 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL stall_cyc%0d rdy=%b v=%b d=%h e=%b exp rdy=0 v=1 d=00008000 e=0",
                     c, req_ready, resp_valid, resp_rdata, resp_err);
         end
         @(posedge CLK); #1;
      end
      resp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
      @(posedge CLK); #1;
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h12348001) begin
         failures++; $display("FAIL b2b_resp v=%b d=%h exp v=1 d=12348001", resp_valid, resp_rdata);
      end
      @(posedge CLK); #1;
      checks++;
      if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", resp_valid); end
   endtask

   task automatic test_reset_midresp;
      resp_ready = 1'b0;
      issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'hBADBAD00; req_valid = 1'b1;
      resp_ready = 1'b1;
      RSTn = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
         failures++; $display("FAIL rst_mid v=%b d=%h exp v=0 d=00000000", resp_valid, resp_rdata);
      end
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      req_valid = 1'b0;
      RSTn = 1'b1;
      @(posedge CLK); #1;
      issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      checks++;
      if (resp_rdata !== 32'h11111111) begin
         failures++; $display("FAIL rst_no_store got=%h exp=11111111", resp_rdata);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset;
      test_word;
      test_byte;
      test_half;
      test_errors;
      test_back_to_back;
      test_reset_midresp;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor to the core's word-only data memory.
- Adds RISC-V byte/half/word load-store sizing with byte-lane write enables and load sign/zero extension.
- Requests use a valid/ready handshake; reads are registered with 1-cycle latency; out-of-range accesses are flagged.
- Sits between the MEM stage and the on-chip data RAM, so the pipeline can stall on resp_valid uniformly.

Parameters:
- DATA_WIDTH, 32, word width in bits; fixed at 32 for RV32; must be a multiple of 8.
- DEPTH, 1024, number of words; power of 2.
- ADDR_WIDTH, 32, width of byte address input.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept request this cycle.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (error).
- req_unsigned  in  1  loads only: 1=zero-extend (LBU/LHU), 0=sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
- resp_err  out  1  access was rejected (range/size/misalign).

Behaviour:
- Reset (RSTn low, async): state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0. Array contents are not reset. A pending response is discarded. No write occurs in any cycle where RSTn is low.
- States:
  - IDLE: no response held.
  - RESP: response held until accepted.
- req_ready = (state==IDLE) | (state==RESP & resp_ready).
- Accept = req_valid & req_ready.
- Transitions:
  - IDLE: accept -> RESP.
  - RESP: resp_ready & accept -> RESP (back-to-back, new response loaded).
  - RESP: resp_ready & !accept -> IDLE.
  - RESP: !resp_ready -> RESP, with outputs held stable.
- Latency: response visible the cycle after accept. Stores also produce a response, with rdata=0.
- Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
- Store, on the accept edge:
  - byte: lane enable 1<<lane, data replicated to all lanes.
  - half: enable 0011<<lane.
  - word: enable 1111.
  - Only enabled bytes are written.
- Load: selected word is read on the accept edge, shifted right by lane*8, masked to size, then extended per req_unsigned. Word loads ignore req_unsigned.
- Error conditions:
  - req_addr >= DEPTH*4
  - req_size==11
  - misalignment (see Optional Feature)
- On error: no write, resp_err=1, resp_rdata=0.
- Read-after-write: a store accepted in cycle N is visible to a load accepted in cycle N+1. There is no same-cycle hazard because only one request is accepted per cycle.

Optional Feature:
- Macro DMEM_MISALIGN_CHK_EN.
- Defined: half with addr[0]!=0, or word with addr[1:0]!=0, raises resp_err with no write.
- Undefined: misaligned low address bits are forced to the natural alignment (half clears addr[0], word clears addr[1:0]) and the access proceeds normally, never flagging misalignment.

Decomposition:
- Shared define file holds:
  - size encodings (SIZE_B/SIZE_H/SIZE_W)
  - state encodings (DMEM_IDLE/DMEM_RESP)
  - existing WriteEnable/ReadEnable constants
- One natural combinational sub-module, dmem_lane_align: store byte-enable/replication plus load shift/extend. The top holds the FSM, response registers and array.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, one cycle after accept.
- SB 0x80 @0x11 over 0x00000000, then LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0x00008000.
- SH 0x1234 @0x22, then LH @0x22 -> 0x00001234; LW @0x20 -> 0x12340000 (lower half unchanged).
- LW @DEPTH*4 -> resp_err=1, rdata=0. With DMEM_MISALIGN_CHK_EN, LW @0x13 -> resp_err=1; without it, returns the word @0x10.
- Hold resp_ready=0 for 3 cycles after a load -> req_ready=0, outputs stable. Then resp_ready=1 with a new req_valid -> back-to-back accept, new response next cycle.
- Assert RSTn low while in RESP with a store presented -> resp_valid=0 immediately, store not committed (verified by a later LW).
